// File: rtl/pairing_wb_arbiter.sv
// Write-back arbiter for the pairing datapath operand RAMs: merges loader, inverter
// and pipeline writes onto one RAM port, replaying colliding pipeline writes from a skid FIFO.
module pairing_wb_arbiter #(
  parameter int DATA_W     = 1216,
  parameter int ADDR_W     = 9,
  parameter int N_BANKS    = 2,
  parameter int LAT_WRITE  = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               busy,
  input  logic               ext_en,
  input  logic [ADDR_W-1:0]  ext_addr,
  input  logic [DATA_W-1:0]  ext_data,
  input  logic [N_BANKS-1:0] pipe_we,
  input  logic [ADDR_W-1:0]  pipe_addr,
  input  logic [DATA_W-1:0]  pipe_data,
  input  logic               inv_rdy,
  input  logic [ADDR_W-1:0]  inv_addr,
  input  logic [DATA_W-1:0]  inv_data,
  output logic [N_BANKS-1:0] we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               skid_empty,
  output logic               skid_full,
  output logic               overflow,
  output logic [15:0]        conflict_cnt
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (LAT_WRITE != 1 && LAT_WRITE != 2) begin : g_bad_lat
    $error("pairing_wb_arbiter: LAT_WRITE must be 1 or 2");
  end
  if (SKID_DEPTH < 2 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pairing_wb_arbiter: SKID_DEPTH must be a power of two >= 2");
  end

  logic [N_BANKS-1:0] r_skid_mask [SKID_DEPTH];
  logic [ADDR_W-1:0]  r_skid_addr [SKID_DEPTH];
  logic [DATA_W-1:0]  r_skid_data [SKID_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_overflow;
  logic [15:0]        r_conflict;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [DATA_W-1:0]  r_last_data;

  logic               w_pipe_req, w_empty, w_full;
  logic               w_push, w_pop, w_push_ok, w_drop, w_conf;
  logic [N_BANKS-1:0] w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  assign w_pipe_req = |pipe_we;
  assign w_empty    = (r_cnt == CNT_W'(0));
  assign w_full     = (r_cnt == CNT_W'(SKID_DEPTH));
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;

  // Priority selection; idle cycles keep the last issued address/data on the port.
  always_comb begin
    w_we   = {N_BANKS{1'b0}};
    w_addr = r_last_addr;
    w_data = r_last_data;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_conf = 1'b0;
    if (!busy) begin
      if (ext_en) begin
        w_we   = {N_BANKS{1'b1}};
        w_addr = ext_addr;
        w_data = ext_data;
      end else begin
        w_we = {N_BANKS{1'b0}};
      end
    end else if (inv_rdy) begin
      w_we   = {N_BANKS{1'b1}};
      w_addr = inv_addr;
      w_data = inv_data;
      w_push = w_pipe_req;
      w_conf = w_pipe_req;
    end else if (!w_empty) begin
      w_we   = r_skid_mask[r_rd_ptr];
      w_addr = r_skid_addr[r_rd_ptr];
      w_data = r_skid_data[r_rd_ptr];
      w_pop  = 1'b1;
      w_push = w_pipe_req;
    end else if (w_pipe_req) begin
      w_we   = pipe_we;
      w_addr = pipe_addr;
      w_data = pipe_data;
    end else begin
      w_we = {N_BANKS{1'b0}};
    end
  end

  // Skid storage; stale slots are harmless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_skid_mask[r_wr_ptr] <= pipe_we;
      r_skid_addr[r_wr_ptr] <= pipe_addr;
      r_skid_data[r_wr_ptr] <= pipe_data;
    end
  end

  // Skid pointers, occupancy, sticky overflow, collision counter and hold registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr    <= PTR_W'(0);
      r_rd_ptr    <= PTR_W'(0);
      r_cnt       <= CNT_W'(0);
      r_overflow  <= 1'b0;
      r_conflict  <= 16'd0;
      r_last_addr <= {ADDR_W{1'b0}};
      r_last_data <= {DATA_W{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      if (w_conf && r_conflict != 16'hFFFF) r_conflict <= r_conflict + 16'd1;
      r_last_addr <= w_addr;
      r_last_data <= w_data;
    end
  end

  assign skid_empty   = w_empty;
  assign skid_full    = w_full;
  assign overflow     = r_overflow;
  assign conflict_cnt = r_conflict;

  if (LAT_WRITE == 1) begin : g_lat1
    assign we    = w_we;
    assign waddr = w_addr;
    assign wdata = w_data;
  end else begin : g_lat2
    logic [N_BANKS-1:0] r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;

    // One-cycle output register for the RAM write port.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_we    <= {N_BANKS{1'b0}};
        r_waddr <= {ADDR_W{1'b0}};
        r_wdata <= {DATA_W{1'b0}};
      end else begin
        r_we    <= w_we;
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end

    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
  end

endmodule

// File: doc/pairing_wb_arbiter.md
Name: pairing_wb_arbiter

Overview:
Parametrised write-back arbiter for the multi-bank operand RAMs of the pairing datapath. It merges three write sources into one shared RAM write port plus per-bank write enables: the external loader, the Montgomery inverter result, and the pipeline post-adder result. Unlike the previous fixed-priority mux, a pipeline write that collides with an inverter write is not lost. It is held in a skid FIFO and replayed in order. Collisions are counted, and any dropped write raises a sticky overflow flag.

Parameters:
DATA_W, 1216, width of one redundant poly word written to RAM
ADDR_W, 9, RAM address width
N_BANKS, 2, number of RAM banks with independent write enables
LAT_WRITE, 2, output latency: 1 = combinational outputs, 2 = registered outputs; other values are illegal (elaboration error)
SKID_DEPTH, 4, entries in the collision skid FIFO; power of two, at least 2

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
busy  in  1  sequencer busy; 0 = external load mode
ext_en  in  1  external write strobe
ext_addr  in  ADDR_W  external write address
ext_data  in  DATA_W  external write data
pipe_we  in  N_BANKS  pipeline per-bank write enables (write-stage micro-op)
pipe_addr  in  ADDR_W  pipeline destination address
pipe_data  in  DATA_W  post-adder output
inv_rdy  in  1  inverter result valid (single cycle)
inv_addr  in  ADDR_W  inverter destination address
inv_data  in  DATA_W  inverter result
we  out  N_BANKS  RAM per-bank write enables
waddr  out  ADDR_W  RAM write address
wdata  out  DATA_W  RAM write data
skid_empty  out  1  skid FIFO empty
skid_full  out  1  skid FIFO full
overflow  out  1  sticky: a pipeline write was dropped
conflict_cnt  out  16  count of inverter/pipeline collisions, saturating

Behaviour:
- A pipeline request exists when the OR-reduction of pipe_we is 1. A skid entry stores the bank mask, address and data.
- busy=0: ext_en selects the external source.
  - The external write goes to all banks: we equals ext_en replicated N_BANKS times.
  - pipe_we and inv_rdy are ignored. The skid neither pushes nor pops and keeps its contents.
- busy=1: per-cycle selection, highest priority first.
  - inv_rdy=1: issue the inverter write to all banks. If a pipeline request is present, push it into the skid and increment conflict_cnt.
  - Otherwise, if the skid is non-empty: issue the skid head and pop it. Push any incoming pipeline request, so FIFO order is preserved.
  - Otherwise, if a pipeline request is present: issue it directly with we=pipe_we.
  - Otherwise: we=0. waddr and wdata hold their last value.
- Push and pop in the same cycle while full: allowed, occupancy is unchanged.
- Push while full with no pop: the write is dropped and overflow is set to 1. overflow stays 1 until reset.
- conflict_cnt saturates at 16'hFFFF. It still increments when the colliding write is dropped.
- Pointers wrap modulo SKID_DEPTH. skid_full and skid_empty are derived from an occupancy counter of width clog2(SKID_DEPTH)+1.
- Latency:
  - LAT_WRITE=1: we, waddr and wdata are combinational from the current-cycle selection.
  - LAT_WRITE=2: the same values, registered once.
  - skid_empty, skid_full, overflow and conflict_cnt are always registered state.
- Reset (rstn=0 at a clock edge, including mid-operation):
  - skid emptied: skid_empty=1, skid_full=0.
  - overflow=0, conflict_cnt=0.
  - we=0, waddr=0, wdata=0, including the output register when LAT_WRITE=2.
  - Any pending skid entries are discarded.
- Throughput: one RAM write per cycle maximum. A skid backlog drains one entry per cycle with no inverter write and no new pipeline request.

Test Plan:
1. busy=0, ext_en=1, ext_addr=5, ext_data=X -> with LAT_WRITE=2, one cycle later we=2'b11, waddr=5, wdata=X. pipe_we=2'b01 in the same cycle has no effect and skid_empty stays 1.
2. busy=1, pipe_we=2'b10, addr=7, no inverter -> we=2'b10, waddr=7 after LAT_WRITE. conflict_cnt=0.
3. busy=1, inv_rdy=1 (addr 3) and pipe_we=2'b01 (addr 9) in the same cycle, then idle -> first write is addr 3 with we=2'b11, next write is addr 9 with we=2'b01. conflict_cnt=1, and skid_empty returns to 1.
4. SKID_DEPTH=4, five consecutive cycles with inv_rdy=1 and a pipeline request each -> skid_full=1 after four, the fifth is dropped, overflow=1, conflict_cnt=5. Then four drain writes follow in push order.
5. Skid holds 2 entries, assert rstn=0 for one cycle -> skid_empty=1, overflow=0, conflict_cnt=0, we=0, and no stale writes are replayed afterwards.
6. Skid full, a cycle with no inverter write and a new pipeline request -> the head is written, the new request is pushed, skid_full stays 1, overflow stays 0.
